// File: rtl/uart_rx_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_decoder
//
// Purpose:
//   Assembles multi-byte command frames from the UART receive path and
//   presents one decoded command at a time over a valid/ready handshake.
//   Malformed, timed-out and overrun frames are reported as single-cycle
//   error pulses. All outputs are registered.
//
//   Frame formats (first byte is the opcode, received in IDLE):
//     0xAA addr data     -> write      (cmd_type 00)
//     0xBB addr          -> read       (cmd_type 01)
//     0xCC opa opb fun   -> ALU        (cmd_type 10)
//     0xDD fun           -> ALU reuse  (cmd_type 11, operands of last 0xCC)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle pulse per correctly received byte
//   rx_par_err   one-cycle pulse: parity error on a received frame
//   rx_stp_err   one-cycle pulse: stop-bit error on a received frame
//   cmd_valid    decoded command available
//   cmd_ready    consumer accepts the command
//   cmd_type     00 write, 01 read, 10 ALU with operands, 11 ALU without
//   cmd_addr     register address (write/read)
//   cmd_wdata    write data
//   cmd_op_a     ALU operand A
//   cmd_op_b     ALU operand B
//   cmd_fun      ALU function
//   err_unknown  pulse: unknown opcode (or bad address byte, see below)
//   err_frame    pulse: parity/stop error seen
//   err_timeout  pulse: inter-byte timeout inside a frame
//   err_overrun  pulse: byte dropped while a command is pending
//
// Build option:
//   UART_RX_CMD_ADDR_CHECK_EN - when defined, an address byte with any bit
//   above ADDR_WIDTH-1 set aborts the frame and pulses err_unknown. When
//   undefined, those upper bits are silently ignored.
// ---------------------------------------------------------------------------
module uart_rx_cmd_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TMO_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_par_err,
    input  logic                  rx_stp_err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_type,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_wdata,
    output logic [7:0]            cmd_op_a,
    output logic [7:0]            cmd_op_b,
    output logic [3:0]            cmd_fun,
    output logic                  err_unknown,
    output logic                  err_frame,
    output logic                  err_timeout,
    output logic                  err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_ALU_A   = 3'd4,
        S_ALU_B   = 3'd5,
        S_ALU_FUN = 3'd6,
        S_ISSUE   = 3'd7
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam bit               TMO_EN   = (TIMEOUT != 0);

    state_t                state_r, state_s;
    logic [TMO_W-1:0]      cnt_r, cnt_s;
    logic                  valid_r, valid_s;
    logic [1:0]            type_r, type_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [7:0]            wdata_r, wdata_s;
    logic [7:0]            op_a_r, op_a_s;
    logic [7:0]            op_b_r, op_b_s;
    logic [3:0]            fun_r, fun_s;
    logic                  eu_r, eu_s;
    logic                  ef_r, ef_s;
    logic                  et_r, et_s;
    logic                  eo_r, eo_s;

    logic                  frame_err_s;
    logic                  in_frame_s;
    logic                  tmo_hit_s;
    logic                  addr_bad_s;

    // Address-byte range check; only active in the checking build.
`ifdef UART_RX_CMD_ADDR_CHECK_EN
    assign addr_bad_s = ((rx_data >> ADDR_WIDTH) != 8'h00);
`else
    assign addr_bad_s = 1'b0;
`endif

    assign frame_err_s = rx_par_err | rx_stp_err;

    // Frame-state qualifier and timeout expiry detection.
    always_comb begin
        in_frame_s = 1'b0;
        case (state_r)
            S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
            S_ALU_A, S_ALU_B, S_ALU_FUN: in_frame_s = 1'b1;
            default:                    in_frame_s = 1'b0;
        endcase
        tmo_hit_s = TMO_EN && in_frame_s && (cnt_r == TMO_LAST);
    end

    // Next-state, field capture and error-pulse decode.
    always_comb begin
        state_s = state_r;
        type_s  = type_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        op_a_s  = op_a_r;
        op_b_s  = op_b_r;
        fun_s   = fun_r;
        eu_s    = 1'b0;
        ef_s    = 1'b0;
        et_s    = 1'b0;
        eo_s    = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (frame_err_s) begin
                    // Error wins over a coincident byte.
                    ef_s = 1'b1;
                end else if (rx_valid) begin
                    case (rx_data)
                        8'hAA: begin
                            state_s = S_WR_ADDR;
                            type_s  = 2'b00;
                        end
                        8'hBB: begin
                            state_s = S_RD_ADDR;
                            type_s  = 2'b01;
                        end
                        8'hCC: begin
                            state_s = S_ALU_A;
                            type_s  = 2'b10;
                        end
                        8'hDD: begin
                            // Operands deliberately kept from the last 0xCC.
                            state_s = S_ALU_FUN;
                            type_s  = 2'b11;
                        end
                        default: begin
                            eu_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_WR_ADDR, S_WR_DATA, S_RD_ADDR,
            S_ALU_A, S_ALU_B, S_ALU_FUN: begin
                if (frame_err_s) begin
                    ef_s    = 1'b1;
                    state_s = S_IDLE;
                end else if (rx_valid) begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    case (state_r)
                        S_WR_ADDR: begin
                            if (addr_bad_s) begin
                                eu_s    = 1'b1;
                                state_s = S_IDLE;
                            end else begin
                                addr_s  = rx_data[ADDR_WIDTH-1:0];
                                state_s = S_WR_DATA;
                            end
                        end
                        S_RD_ADDR: begin
                            if (addr_bad_s) begin
                                eu_s    = 1'b1;
                                state_s = S_IDLE;
                            end else begin
                                addr_s  = rx_data[ADDR_WIDTH-1:0];
                                state_s = S_ISSUE;
                            end
                        end
                        S_WR_DATA: begin
                            wdata_s = rx_data;
                            state_s = S_ISSUE;
                        end
                        S_ALU_A: begin
                            op_a_s  = rx_data;
                            state_s = S_ALU_B;
                        end
                        S_ALU_B: begin
                            op_b_s  = rx_data;
                            state_s = S_ALU_FUN;
                        end
                        S_ALU_FUN: begin
                            fun_s   = rx_data[3:0];
                            state_s = S_ISSUE;
                        end
                        default: begin
                            state_s = S_IDLE;
                        end
                    endcase
                end else if (tmo_hit_s) begin
                    et_s    = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    state_s = state_r;
                end
            end

            S_ISSUE: begin
                // Incoming traffic never disturbs the pending command.
                if (frame_err_s) begin
                    ef_s = 1'b1;
                end else if (rx_valid) begin
                    eo_s = 1'b1;
                end else begin
                    eo_s = 1'b0;
                end
                if (cmd_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_ISSUE;
                end
            end

            default: begin
                state_s = S_IDLE;
            end
        endcase

        valid_s = (state_s == S_ISSUE);

        // Counter runs only while staying in the same frame state; any
        // accepted byte or exit changes state and therefore clears it.
        if (TMO_EN && in_frame_s && (state_s == state_r)) begin
            cnt_s = cnt_r + TMO_ONE;
        end else begin
            cnt_s = {TMO_W{1'b0}};
        end
    end

    // State, counter and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {TMO_W{1'b0}};
            valid_r <= 1'b0;
            type_r  <= 2'b00;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= 8'h00;
            op_a_r  <= 8'h00;
            op_b_r  <= 8'h00;
            fun_r   <= 4'h0;
            eu_r    <= 1'b0;
            ef_r    <= 1'b0;
            et_r    <= 1'b0;
            eo_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            valid_r <= valid_s;
            type_r  <= type_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            op_a_r  <= op_a_s;
            op_b_r  <= op_b_s;
            fun_r   <= fun_s;
            eu_r    <= eu_s;
            ef_r    <= ef_s;
            et_r    <= et_s;
            eo_r    <= eo_s;
        end
    end

    assign cmd_valid   = valid_r;
    assign cmd_type    = type_r;
    assign cmd_addr    = addr_r;
    assign cmd_wdata   = wdata_r;
    assign cmd_op_a    = op_a_r;
    assign cmd_op_b    = op_b_r;
    assign cmd_fun     = fun_r;
    assign err_unknown = eu_r;
    assign err_frame   = ef_r;
    assign err_timeout = et_r;
    assign err_overrun = eo_r;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cmd_decoder
//
// Purpose:
//   Table-driven directed test of uart_rx_cmd_decoder with default
//   parameters (ADDR_WIDTH=4, TIMEOUT=1024), followed by hand-written
//   sequences for the timeout, byte-at-expiry and reset corner cases.
//   Each table row drives one clock of inputs; the expected value is the
//   full registered output vector after that clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_par_err;
    logic       rx_stp_err;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_op_a;
    logic [7:0] cmd_op_b;
    logic [3:0] cmd_fun;
    logic       err_unknown;
    logic       err_frame;
    logic       err_timeout;
    logic       err_overrun;

    int errors = 0;
    int checks = 0;

    // ctl encoding: {rx_valid, rx_par_err, rx_stp_err, cmd_ready}
    localparam logic [3:0] N  = 4'b0000;
    localparam logic [3:0] V  = 4'b1000;
    localparam logic [3:0] PE = 4'b0100;
    localparam logic [3:0] SE = 4'b0010;
    localparam logic [3:0] R  = 4'b0001;

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  c;
        logic [38:0] e;
    } vec_t;

    vec_t vq[$];

    uart_rx_cmd_decoder #(
        .ADDR_WIDTH (4),
        .TIMEOUT    (1024),
        .TMO_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_par_err  (rx_par_err),
        .rx_stp_err  (rx_stp_err),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_op_a    (cmd_op_a),
        .cmd_op_b    (cmd_op_b),
        .cmd_fun     (cmd_fun),
        .err_unknown (err_unknown),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    logic [38:0] outs;
    assign outs = {cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b,
                   cmd_fun, err_unknown, err_frame, err_timeout, err_overrun};

    // e = {err_unknown, err_frame, err_timeout, err_overrun}
    function automatic logic [38:0] ex(input logic v, input logic [1:0] t,
                                       input logic [3:0] ad, input logic [7:0] wd,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] f, input logic [3:0] e);
        return {v, t, ad, wd, a, b, f, e};
    endfunction

    function automatic void add(input logic [7:0] d, input logic [3:0] c,
                                input logic [38:0] e);
        vec_t r;
        r.d = d;
        r.c = c;
        r.e = e;
        vq.push_back(r);
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic [7:0] d, input logic [3:0] c);
        rx_data    = d;
        rx_valid   = c[3];
        rx_par_err = c[2];
        rx_stp_err = c[1];
        cmd_ready  = c[0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [38:0] e);
        checks++;
        if (outs !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, outs, e);
        end
    endtask

    initial begin
        int bad;

        // Write frame AA,05,3C with ready high
        add(8'hAA, V | R, ex(1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 4'b0000));
        add(8'h05, V | R, ex(1'b0, 2'd0, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 4'b0000));
        add(8'h3C, V | R, ex(1'b1, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 4'b0000));
        add(8'h00, R,     ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 4'b0000));
        // ALU frame CC,12,34,03 with ready held low
        add(8'hCC, V,     ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 4'b0000));
        add(8'h12, V,     ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h00, 4'h0, 4'b0000));
        add(8'h34, V,     ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h0, 4'b0000));
        add(8'h03, V,     ex(1'b1, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h3, 4'b0000));
        for (int k = 0; k < 4; k++)
            add(8'h00, N, ex(1'b1, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h3, 4'b0000));
        add(8'h00, R,     ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h3, 4'b0000));
        // DD,01 reuses operands
        add(8'hDD, V,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h3, 4'b0000));
        add(8'h01, V,     ex(1'b1, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h00, R,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        // Unknown opcode, then read frame BB,07
        add(8'h55, V,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b1000));
        add(8'h00, N,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'hBB, V,     ex(1'b0, 2'd1, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h07, V,     ex(1'b1, 2'd1, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        // Overrun and frame error while pending; overrun with ready high
        add(8'h99, V,     ex(1'b1, 2'd1, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0001));
        add(8'h00, N,     ex(1'b1, 2'd1, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h00, PE,    ex(1'b1, 2'd1, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0100));
        add(8'h44, V | R, ex(1'b0, 2'd1, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0001));
        // AA,05 then parity error discards the frame
        add(8'hAA, V,     ex(1'b0, 2'd0, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h05, V,     ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h00, PE,    ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0100));
        add(8'h3C, V,     ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b1000));
        // Byte coinciding with stop error is ignored
        add(8'hAA, V | SE, ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0100));
        add(8'h05, V,     ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b1000));
        // Read with upper address bits set
        add(8'hBB, V,     ex(1'b0, 2'd1, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
`ifdef UART_RX_CMD_ADDR_CHECK_EN
        add(8'h15, V,     ex(1'b0, 2'd1, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b1000));
`else
        add(8'h15, V,     ex(1'b1, 2'd1, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
`endif
        add(8'h00, R,     ex(1'b0, 2'd1, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        // Stop error aborts ALU frame; DD then keeps old operands, fun upper nibble ignored
        add(8'hCC, V,     ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'h00, SE,    ex(1'b0, 2'd2, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0100));
        add(8'hDD, V,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'h1, 4'b0000));
        add(8'hAF, V,     ex(1'b1, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b0000));
        add(8'h00, R,     ex(1'b0, 2'd3, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b0000));

        // Reset
        rst = 1'b1;
        step(8'h00, N);
        step(8'h00, N);
        chk("reset", 39'h0);
        rst = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].d, vq[i].c);
            chk($sformatf("vec%0d", i), vq[i].e);
        end

        // Timeout: AA then 1023 quiet cycles without error, then pulse
        step(8'hAA, V);
        chk("tmo_start", ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b0000));
        bad = 0;
        for (int k = 0; k < 1023; k++) begin
            step(8'h00, N);
            if (outs[3:0] != 4'b0000 || cmd_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tmo_early: got %0d bad cycles expected 0", bad);
        end
        step(8'h00, N);
        chk("tmo_pulse", ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b0010));
        step(8'h02, V);
        chk("tmo_idle_02", ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b1000));
        step(8'h33, V);
        chk("tmo_idle_33", ex(1'b0, 2'd0, 4'h5, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b1000));

        // Byte arriving on the expiry cycle wins
        step(8'hAA, V);
        for (int k = 0; k < 1023; k++) step(8'h00, N);
        step(8'h07, V);
        chk("tmo_byte_wins", ex(1'b0, 2'd0, 4'h7, 8'h3C, 8'h12, 8'h34, 4'hF, 4'b0000));
        step(8'h5A, V);
        chk("tmo_issue", ex(1'b1, 2'd0, 4'h7, 8'h5A, 8'h12, 8'h34, 4'hF, 4'b0000));
        step(8'h00, N);
        chk("hold", ex(1'b1, 2'd0, 4'h7, 8'h5A, 8'h12, 8'h34, 4'hF, 4'b0000));

        // Reset during ISSUE drops the command, no error pulse
        rst = 1'b1;
        step(8'h00, N);
        chk("rst_issue", 39'h0);
        rst = 1'b0;
        step(8'h00, N);
        chk("rst_quiet", 39'h0);
        step(8'h05, V);
        chk("rst_idle", ex(1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 4'b1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
